// File: rtl/reg_file.sv
// Write-back register file: one-cycle staging register in front of the array,
// two general read ports and a dedicated R0 port, all forwarded from staging.

module reg_file_rport #(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
    input  logic                           wb_valid,
    input  logic [ADDR_W-1:0]              wb_reg,
    input  logic [WIDTH-1:0]               wb_data,
    input  logic [ADDR_W-1:0]              idx,
    output logic [WIDTH-1:0]               data
);
    // Staged value is newer than anything in the array, so it wins on a hit.
    assign data = (wb_valid && (wb_reg == idx)) ? wb_data : regs[idx];
endmodule

module reg_file #(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteValue,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic [WIDTH-1:0]  ReadR0,
    output logic              WbPending
);
    localparam int NUM_RPORTS = 3;

    logic [NUM_REGS-1:0][WIDTH-1:0]   regs;
    logic                             wb_valid;
    logic [ADDR_W-1:0]                wb_reg;
    logic [WIDTH-1:0]                 wb_data;
    logic [NUM_RPORTS-1:0][ADDR_W-1:0] rd_idx;
    logic [NUM_RPORTS-1:0][WIDTH-1:0]  rd_data;

    // Commit uses the staging contents from before this edge's capture.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            regs <= '0;
        end else if (wb_valid) begin
            regs[wb_reg] <= wb_data;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= RegWrite;
            if (RegWrite) begin
                wb_reg  <= WriteReg;
                wb_data <= WriteValue;
            end
        end
    end

    assign rd_idx[0] = ReadReg1;
    assign rd_idx[1] = ReadReg2;
    assign rd_idx[2] = '0;

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        reg_file_rport #(
            .NUM_REGS (NUM_REGS),
            .WIDTH    (WIDTH),
            .ADDR_W   (ADDR_W)
        ) u_rport (
            .regs     (regs),
            .wb_valid (wb_valid),
            .wb_reg   (wb_reg),
            .wb_data  (wb_data),
            .idx      (rd_idx[p]),
            .data     (rd_data[p])
        );
    end

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];
    assign ReadR0    = rd_data[2];
    assign WbPending = wb_valid;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: table vectors through a scoreboard queue, plus
// hand sequences for async reset, reset mid-write and streaming.

module tb_reg_file;
    localparam int NUM_REGS = 16;
    localparam int WIDTH    = 8;
    localparam int ADDR_W   = 4;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [WIDTH-1:0]  WriteValue;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic [WIDTH-1:0]  ReadR0;
    logic              WbPending;

    reg_file #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteValue (WriteValue),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .ReadR0     (ReadR0),
        .WbPending  (WbPending)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wr;
        logic [WIDTH-1:0]  wv;
        logic [ADDR_W-1:0] r1;
        logic [ADDR_W-1:0] r2;
        logic [WIDTH-1:0]  e1;
        logic [WIDTH-1:0]  e2;
        logic [WIDTH-1:0]  e0;
        logic              ep;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a write/read pair at the falling edge, then clock once.
    task automatic drive(input logic we, input logic [ADDR_W-1:0] wr, input logic [WIDTH-1:0] wv,
                         input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        @(negedge CLK);
        RegWrite = we; WriteReg = wr; WriteValue = wv;
        ReadReg1 = r1; ReadReg2 = r2;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd5, 8'hA7, 4'd5, 4'd0, 8'hA7, 8'h00, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 4'd0, 8'h00, 4'd5, 4'd5, 8'hA7, 8'hA7, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 4'd2, 8'h11, 4'd5, 4'd2, 8'hA7, 8'h11, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 4'd2, 8'h22, 4'd2, 4'd2, 8'h22, 8'h22, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 4'd0, 8'h00, 4'd2, 4'd2, 8'h22, 8'h22, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 4'd0, 8'hFF, 4'd0, 4'd1, 8'hFF, 8'h00, 8'hFF, 1'b1};
        vecs[6] = '{1'b1, 4'd9, 8'h3C, 4'd0, 4'd9, 8'hFF, 8'h3C, 8'hFF, 1'b1};
        vecs[7] = '{1'b1, 4'd0, 8'h01, 4'd9, 4'd2, 8'h3C, 8'h22, 8'h01, 1'b1};
        vecs[8] = '{1'b0, 4'd0, 8'h00, 4'd0, 4'd5, 8'h01, 8'hA7, 8'h01, 1'b0};

        Reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteValue = '0;
        ReadReg1 = '0; ReadReg2 = '0;
        #12;
        check("reset_rd1", ReadData1, 8'h00);
        check("reset_r0", ReadR0, 8'h00);
        check("reset_pend", {7'd0, WbPending}, 8'h00);
        @(negedge CLK);
        Reset = 1'b0;

        // Old value visible before the first capture edge.
        @(negedge CLK);
        RegWrite = 1'b1; WriteReg = 4'd5; WriteValue = 8'hA7; ReadReg1 = 4'd5;
        #1;
        check("pre_edge_rd1", ReadData1, 8'h00);
        RegWrite = 1'b0;

        for (int i = 0; i < 9; i++) begin
            sb.push_back(vecs[i]);
            drive(vecs[i].we, vecs[i].wr, vecs[i].wv, vecs[i].r1, vecs[i].r2);
            begin
                vec_t e;
                e = sb.pop_front();
                check($sformatf("v%0d_rd1", i), ReadData1, e.e1);
                check($sformatf("v%0d_rd2", i), ReadData2, e.e2);
                check($sformatf("v%0d_r0", i), ReadR0, e.e0);
                check($sformatf("v%0d_pend", i), {7'd0, WbPending}, {7'd0, e.ep});
            end
        end

        // Async reset between edges with a committed R3 and a pending R4.
        drive(1'b1, 4'd3, 8'h5A, 4'd3, 4'd4);
        drive(1'b1, 4'd4, 8'h77, 4'd3, 4'd4);
        check("r3_committed", ReadData1, 8'h5A);
        check("r4_staged", ReadData2, 8'h77);
        @(negedge CLK);
        RegWrite = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("async_rd1", ReadData1, 8'h00);
        check("async_rd2", ReadData2, 8'h00);
        check("async_r0", ReadR0, 8'h00);
        check("async_pend", {7'd0, WbPending}, 8'h00);
        @(negedge CLK);
        Reset = 1'b0;

        // Reset mid-write: captured R7 must never reach the array.
        drive(1'b1, 4'd7, 8'h3C, 4'd7, 4'd4);
        check("r7_staged", ReadData1, 8'h3C);
        @(negedge CLK);
        RegWrite = 1'b0;
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        drive(1'b0, 4'd0, 8'h00, 4'd7, 4'd4);
        drive(1'b0, 4'd0, 8'h00, 4'd7, 4'd4);
        check("r7_discarded", ReadData1, 8'h00);
        check("r4_discarded", ReadData2, 8'h00);

        // Streaming: one write per cycle to every register.
        for (int i = 0; i < NUM_REGS; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(i);
            drive(1'b1, a, 8'h10 + 8'(i), a, 4'd0);
            check($sformatf("stream_fwd%0d", i), ReadData1, 8'h10 + 8'(i));
        end
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
        check("stream_pend", {7'd0, WbPending}, 8'h00);
        check("stream_r0", ReadR0, 8'h10);
        for (int i = 0; i < NUM_REGS; i++) begin
            ReadReg1 = ADDR_W'(i);
            ReadReg2 = ADDR_W'(NUM_REGS - 1 - i);
            #1;
            check($sformatf("stream_rd1_%0d", i), ReadData1, 8'h10 + 8'(i));
            check($sformatf("stream_rd2_%0d", i), ReadData2, 8'h10 + 8'(NUM_REGS - 1 - i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
